// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the CPU/DMA single-port RAM arbiter.
`ifndef MEM_ARBITER_PKG_SV
`define MEM_ARBITER_PKG_SV
package mem_arbiter_pkg;

  localparam int unsigned WAIT_W = 8;

  // Which port owns the read whose data returns next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

endpackage
`endif

// File: rtl/mem_arbiter_if.sv
// Bundle of the CPU port, DMA port and RAM-side signals of the arbiter.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  ram_rdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output ram_addr, ram_we, ram_wdata
  );

  // Requesters and RAM side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output ram_rdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/mem_arbiter_wait_counter.sv
// Saturating count of consecutive denied DMA cycles; at_limit_o grants DMA forced priority.
module mem_arbiter_wait_counter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic inc_i,
  output logic at_limit_o
);

  localparam logic [WAIT_W-1:0] Limit = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != Limit)) begin
      cnt_d = cnt_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit_o = (cnt_q == Limit);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: CPU has fixed priority, DMA is guaranteed a slot after MAX_WAIT denials.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned MAX_WAIT = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  logic   dma_prio;
  logic   cpu_gnt;
  logic   dma_gnt;
  owner_e rd_owner_q, rd_owner_d;

  mem_arbiter_wait_counter #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_counter (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (dma_gnt | ~bus.dma_req),
    .inc_i     (bus.dma_req & ~dma_gnt),
    .at_limit_o(dma_prio)
  );

  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (!reset) begin
      if (dma_prio && bus.dma_req) begin
        dma_gnt = 1'b1;
      end else if (bus.cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (bus.dma_req) begin
        dma_gnt = 1'b1;
      end
    end
  end

  // With no grant the RAM still sees the CPU address/data, just never a write.
  always_comb begin
    bus.ram_addr  = bus.cpu_addr;
    bus.ram_wdata = bus.cpu_wdata;
    bus.ram_we    = cpu_gnt & bus.cpu_we;
    if (reset) begin
      bus.ram_addr  = '0;
      bus.ram_wdata = '0;
      bus.ram_we    = 1'b0;
    end else if (dma_gnt) begin
      bus.ram_addr  = bus.dma_addr;
      bus.ram_wdata = bus.dma_wdata;
      bus.ram_we    = bus.dma_we;
    end
  end

  always_comb begin
    rd_owner_d = OWN_NONE;
    if (cpu_gnt && !bus.cpu_we) begin
      rd_owner_d = OWN_CPU;
    end else if (dma_gnt && !bus.dma_we) begin
      rd_owner_d = OWN_DMA;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_owner_q <= OWN_NONE;
    end else begin
      rd_owner_q <= rd_owner_d;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dma_gnt    = dma_gnt;
  assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt;
  // Reads still in flight when reset rises are dropped.
  assign bus.cpu_rvalid = (rd_owner_q == OWN_CPU) & ~reset;
  assign bus.dma_rvalid = (rd_owner_q == OWN_DMA) & ~reset;
  assign bus.cpu_rdata  = bus.ram_rdata;
  assign bus.dma_rdata  = bus.ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised scoreboard bench for mem_arbiter (MAX_WAIT=4), plus a MAX_WAIT=1 alternation check.
module tb_mem_arbiter;

  localparam int MaxWait = 4;

  typedef struct {
    int          due;
    bit          is_dma;
    bit          chk;
    logic [15:0] data;
  } rd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();
  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus1 ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(MaxWait)) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bus)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_WAIT(1)) dut1 (
    .clk  (clk),
    .reset(rst),
    .bus  (bus1)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int denied = 0;
  rd_t sb[$];
  logic [15:0] ref_mem[logic [15:0]];
  logic [15:0] env_mem[65536];

  // Environment RAM: synchronous read, data one cycle after the access.
  always @(posedge clk) begin
    if (bus.ram_we) env_mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= env_mem[bus.ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_seq(input string name, input string act, input string exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rand_addr();
    return ($urandom_range(0, 1) != 0 ? 16'h4000 : 16'h0010) + 16'($urandom_range(0, 7));
  endfunction

  // One bus cycle: drive, predict from the arbitration rules, check, update the model.
  task automatic step(input bit r,
                      input bit cr, input bit cw, input logic [15:0] ca, input logic [15:0] cd,
                      input bit dr, input bit dw, input logic [15:0] da, input logic [15:0] dd,
                      output string win);
    bit          gc, gd, w;
    logic [15:0] a, exp_a, exp_d;
    rd_t         e;
    @(posedge clk);
    #1;
    cyc++;
    rst = r;
    bus.cpu_req = cr; bus.cpu_we = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.dma_req = dr; bus.dma_we = dw; bus.dma_addr = da; bus.dma_wdata = dd;
    if (r) while (sb.size() > 0 && sb[$].due == cyc) void'(sb.pop_back());
    gd = !r && dr && (denied >= MaxWait || !cr);
    gc = !r && cr && !gd;
    exp_a = r ? 16'h0 : (gd ? da : ca);
    exp_d = r ? 16'h0 : (gd ? dd : cd);
    #3;
    chk("cpu_gnt", 32'(bus.cpu_gnt), 32'(gc));
    chk("dma_gnt", 32'(bus.dma_gnt), 32'(gd));
    chk("cpu_stall", 32'(bus.cpu_stall), 32'(cr && !gc));
    chk("ram_we", 32'(bus.ram_we), 32'((gc && cw) || (gd && dw)));
    chk("ram_addr", 32'(bus.ram_addr), 32'(exp_a));
    chk("ram_wdata", 32'(bus.ram_wdata), 32'(exp_d));
    if (gc || gd) begin
      a = gd ? da : ca;
      w = gd ? dw : cw;
      if (w) begin
        ref_mem[a] = gd ? dd : cd;
      end else begin
        e.due = cyc + 1;
        e.is_dma = gd;
        e.chk = ref_mem.exists(a);
        e.data = e.chk ? ref_mem[a] : 16'h0;
        sb.push_back(e);
      end
    end
    if (r || !dr || gd) denied = 0;
    else if (denied < MaxWait) denied++;
    win = gc ? "C" : (gd ? "D" : "-");
  endtask

  // Read-return monitor for the main DUT.
  rd_t mon_e;
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        mon_e = sb.pop_front();
        chk("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(!mon_e.is_dma));
        chk("dma_rvalid", 32'(bus.dma_rvalid), 32'(mon_e.is_dma));
        if (mon_e.chk)
          chk("rdata", 32'(mon_e.is_dma ? bus.dma_rdata : bus.cpu_rdata), 32'(mon_e.data));
      end else begin
        chk("rvalid_idle", 32'({bus.cpu_rvalid, bus.dma_rvalid}), 32'(0));
      end
    end
  end

  // MAX_WAIT=1 instance under permanent read contention must alternate CPU, DMA, ...
  initial begin
    bus1.cpu_req = 1'b1; bus1.cpu_we = 1'b0; bus1.cpu_addr = 16'h0010; bus1.cpu_wdata = 16'h0;
    bus1.dma_req = 1'b1; bus1.dma_we = 1'b0; bus1.dma_addr = 16'h4000; bus1.dma_wdata = 16'h0;
    bus1.ram_rdata = 16'h0;
  end

  bit p1_prev_cpu = 1'b0;
  bit p1_prev_dma = 1'b0;
  bit p1_prev_rst = 1'b1;
  always @(negedge clk) begin
    if (cyc >= 1) begin
      if (rst) begin
        chk("alt_gnt_rst", 32'({bus1.cpu_gnt, bus1.dma_gnt}), 32'(0));
      end else begin
        chk("alt_cpu_gnt", 32'(bus1.cpu_gnt), 32'(!p1_prev_cpu));
        chk("alt_dma_gnt", 32'(bus1.dma_gnt), 32'(p1_prev_cpu));
      end
      chk("alt_cpu_rvalid", 32'(bus1.cpu_rvalid), 32'(!rst && p1_prev_cpu && !p1_prev_rst));
      chk("alt_dma_rvalid", 32'(bus1.dma_rvalid), 32'(!rst && p1_prev_dma && !p1_prev_rst));
      p1_prev_cpu <= bus1.cpu_gnt;
      p1_prev_dma <= bus1.dma_gnt;
      p1_prev_rst <= rst;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    string       w, seq;
    bit          ca_act, da_act, cw, dw, r;
    logic [15:0] caddr, cwd, daddr, dwd;

    repeat (2) step(1, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0, w);

    // CPU only: write then read back.
    step(0, 1, 1, 16'h0010, 16'hBEEF, 0, 0, 16'h0, 16'h0, w);
    step(0, 1, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, w);
    step(0, 0, 0, 16'h0010, 16'h0, 0, 0, 16'h0, 16'h0, w);

    // DMA only: load 1234 then read it.
    step(0, 0, 0, 16'h0010, 16'h0, 1, 1, 16'h4000, 16'h1234, w);
    step(0, 0, 0, 16'h0010, 16'h0, 1, 0, 16'h4000, 16'h0, w);
    step(0, 0, 0, 16'h0010, 16'h0, 0, 0, 16'h4000, 16'h0, w);

    // Continuous contention.
    seq = "";
    repeat (10) begin
      step(0, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h4000, 16'h0, w);
      seq = {seq, w};
    end
    chk_seq("contention_seq", seq, "CCCCDCCCCD");
    step(0, 0, 0, 16'h0010, 16'h0, 0, 0, 16'h4000, 16'h0, w);

    // DMA withdraws after two denials; the wait count must restart.
    seq = "";
    repeat (2) begin
      step(0, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h4000, 16'h0, w);
      seq = {seq, w};
    end
    step(0, 1, 0, 16'h0010, 16'h0, 0, 0, 16'h4000, 16'h0, w);
    seq = {seq, w};
    repeat (5) begin
      step(0, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h4000, 16'h0, w);
      seq = {seq, w};
    end
    chk_seq("dma_abort_seq", seq, "CCCCCCCD");
    step(0, 0, 0, 16'h0010, 16'h0, 0, 0, 16'h4000, 16'h0, w);

    // Reset right after a CPU read grant.
    seq = "";
    step(0, 1, 0, 16'h0010, 16'h0, 0, 0, 16'h4000, 16'h0, w);
    seq = {seq, w};
    repeat (2) begin
      step(1, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h4000, 16'h0, w);
      seq = {seq, w};
    end
    step(0, 1, 0, 16'h0010, 16'h0, 1, 0, 16'h4000, 16'h0, w);
    seq = {seq, w};
    chk_seq("reset_seq", seq, "C--C");
    step(0, 0, 0, 16'h0010, 16'h0, 0, 0, 16'h4000, 16'h0, w);

    // Random traffic; requests held until granted, occasional aborts and resets.
    ca_act = 0; da_act = 0; cw = 0; dw = 0;
    caddr = 16'h0010; daddr = 16'h4000; cwd = 16'h0; dwd = 16'h0;
    for (int i = 0; i < 3000; i++) begin
      if (!ca_act && $urandom_range(0, 2) != 0) begin
        ca_act = 1; cw = 1'($urandom_range(0, 1)); caddr = rand_addr(); cwd = 16'($urandom);
      end else if (ca_act && $urandom_range(0, 15) == 0) begin
        ca_act = 0;
      end
      if (!da_act && $urandom_range(0, 2) != 0) begin
        da_act = 1; dw = 1'($urandom_range(0, 1)); daddr = rand_addr(); dwd = 16'($urandom);
      end else if (da_act && $urandom_range(0, 15) == 0) begin
        da_act = 0;
      end
      r = ($urandom_range(0, 63) == 0);
      step(r, ca_act, cw, caddr, cwd, da_act, dw, daddr, dwd, w);
      if (w == "C") ca_act = 0;
      if (w == "D") da_act = 0;
    end

    repeat (3) step(0, 0, 0, 16'h0010, 16'h0, 0, 0, 16'h4000, 16'h0, w);
    @(posedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
